// File: rtl/fq_pkg.sv
// Shared constants and helpers for the instruction prefetch queue.
package fq_pkg;

  localparam int          LINE_BYTES        = 16;
  localparam int          BUF_BYTES         = 32;
  localparam logic [3:0]  MAX_INSTR_LEN     = 4'd15;
  localparam logic [5:0]  IR_V_MIN          = 6'd15;
  localparam logic [5:0]  FULL_CNT          = 6'd32;
  localparam logic [31:0] RESET_EIP_DEFAULT = 32'h0000_0000;

  // Round an address down to the start of its I-cache line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

endpackage

// File: rtl/fq_checker.sv
// Protocol and sanity checks for the prefetch queue.
module fq_checker
  import fq_pkg::*;
(
  input logic       clk,
  input logic       clr,
  input logic       instr_take,
  input logic [3:0] instr_len,
  input logic [5:0] byte_cnt
);

  // Decode must never consume a zero-length instruction.
  a_len_nonzero: assert property (@(posedge clk) disable iff (!clr)
    instr_take |-> (instr_len != 4'd0));

  // The buffer can never report more bytes than its two lines hold.
  a_cnt_range: assert property (@(posedge clk) disable iff (!clr)
    byte_cnt <= FULL_CNT);

endmodule

// File: rtl/fq_rotate32x16.sv
// Extracts a 16-byte window from the 32-byte circular buffer starting at head.
module fq_rotate32x16
  import fq_pkg::*;
(
  input  logic [BUF_BYTES-1:0][7:0]   bytes,
  input  logic [4:0]                  head,
  output logic [LINE_BYTES*8-1:0]     window
);

  // Window byte k sits in the most-significant end first; index wraps mod 32.
  always_comb begin
    window = '0;
    for (int k = 0; k < LINE_BYTES; k++) begin
      window[LINE_BYTES*8-1-8*k -: 8] = bytes[head + 5'(k)];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: two-line circular byte buffer feeding decode.
module fetch_queue
  import fq_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = RESET_EIP_DEFAULT
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         FLUSH,
  input  logic [31:0]  FLUSH_EIP,
  output logic         IC_REQ,
  output logic [31:0]  IC_ADDR,
  input  logic         IC_RDY,
  input  logic [127:0] IC_LINE,
  input  logic         DE_STALL,
  input  logic         INSTR_TAKE,
  input  logic [3:0]   INSTR_LEN,
  output logic [127:0] IR_OUT,
  output logic         IR_V,
  output logic [31:0]  EIP_OUT,
  output logic [5:0]   BYTE_CNT
);

  logic [BUF_BYTES-1:0][7:0] buf_bytes_r;
  logic [1:0]  slot_v_r, slot_v_s;
  logic [4:0]  head_r, head_s;
  logic        tail_r, tail_s;
  logic [3:0]  skip_r, skip_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [31:0] eip_r, eip_s;
  logic [31:0] faddr_r, faddr_s;

  logic        ic_req_s;
  logic        ir_v_s;
  logic        fill_s;
  logic        consume_s;
  logic [4:0]  head_sum_s;
  logic        cross_s;
  logic [5:0]  fill_add_s;
  logic [5:0]  take_sub_s;

  // A request is outstanding while the slot to fill is empty; a redirect suppresses it.
  assign ic_req_s   = ~slot_v_r[tail_r] & ~FLUSH;
  assign ir_v_s     = (cnt_r >= IR_V_MIN) & ~FLUSH;
  assign fill_s     = ic_req_s & IC_RDY;
  assign consume_s  = ir_v_s & INSTR_TAKE & ~DE_STALL & (INSTR_LEN != 4'd0);
  assign head_sum_s = head_r + {1'b0, INSTR_LEN};
  assign cross_s    = head_sum_s[4] != head_r[4];
  assign fill_add_s = fill_s ? (6'd16 - {2'b00, skip_r}) : 6'd0;
  assign take_sub_s = consume_s ? {2'b00, INSTR_LEN} : 6'd0;

  // Next-state: flush overrides everything; otherwise fill and consume combine.
  always_comb begin
    slot_v_s = slot_v_r;
    head_s   = head_r;
    tail_s   = tail_r;
    skip_s   = skip_r;
    cnt_s    = cnt_r;
    eip_s    = eip_r;
    faddr_s  = faddr_r;
    if (FLUSH) begin
      slot_v_s = 2'b00;
      tail_s   = 1'b0;
      head_s   = {1'b0, FLUSH_EIP[3:0]};
      skip_s   = FLUSH_EIP[3:0];
      cnt_s    = 6'd0;
      eip_s    = FLUSH_EIP;
      faddr_s  = line_align(FLUSH_EIP);
    end else begin
      if (fill_s) begin
        slot_v_s[tail_r] = 1'b1;
        tail_s           = ~tail_r;
        faddr_s          = faddr_r + 32'd16;
        skip_s           = 4'd0;
      end else begin
        skip_s = skip_r;
      end
      if (consume_s) begin
        head_s = head_sum_s;
        eip_s  = eip_r + {28'd0, INSTR_LEN};
        if (cross_s) begin
          // The slot head just left holds no more live bytes.
          slot_v_s[head_r[4]] = 1'b0;
        end else begin
          slot_v_s[head_r[4]] = slot_v_s[head_r[4]];
        end
      end else begin
        head_s = head_r;
      end
      cnt_s = cnt_r + fill_add_s - take_sub_s;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      slot_v_r <= 2'b00;
      head_r   <= {1'b0, RESET_EIP[3:0]};
      tail_r   <= 1'b0;
      skip_r   <= RESET_EIP[3:0];
      cnt_r    <= 6'd0;
      eip_r    <= RESET_EIP;
      faddr_r  <= line_align(RESET_EIP);
    end else begin
      slot_v_r <= slot_v_s;
      head_r   <= head_s;
      tail_r   <= tail_s;
      skip_r   <= skip_s;
      cnt_r    <= cnt_s;
      eip_r    <= eip_s;
      faddr_r  <= faddr_s;
    end
  end

  // Line data lands in the tail slot; byte 0 of the line is its lowest byte.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      buf_bytes_r <= '0;
    end else if (fill_s) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        buf_bytes_r[{tail_r, 4'(i)}] <= IC_LINE[8*i +: 8];
      end
    end else begin
      buf_bytes_r <= buf_bytes_r;
    end
  end

  fq_rotate32x16 u_rotate (
    .bytes  (buf_bytes_r),
    .head   (head_r),
    .window (IR_OUT)
  );

  fq_checker u_checker (
    .clk        (CLK),
    .clr        (CLR),
    .instr_take (INSTR_TAKE),
    .instr_len  (INSTR_LEN),
    .byte_cnt   (cnt_r)
  );

  assign IC_REQ   = ic_req_s;
  assign IC_ADDR  = faddr_r;
  assign IR_V     = ir_v_s;
  assign EIP_OUT  = eip_r;
  assign BYTE_CNT = cnt_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic.
module tb_fetch_queue;
  import fq_pkg::*;

  logic         CLK = 1'b0;
  logic         CLR;
  logic         FLUSH;
  logic [31:0]  FLUSH_EIP;
  logic         IC_REQ;
  logic [31:0]  IC_ADDR;
  logic         IC_RDY;
  logic [127:0] IC_LINE;
  logic         DE_STALL;
  logic         INSTR_TAKE;
  logic [3:0]   INSTR_LEN;
  logic [127:0] IR_OUT;
  logic         IR_V;
  logic [31:0]  EIP_OUT;
  logic [5:0]   BYTE_CNT;

  always #5 CLK = ~CLK;

  fetch_queue #(.RESET_EIP(32'h0000_0000)) dut (
    .CLK(CLK), .CLR(CLR), .FLUSH(FLUSH), .FLUSH_EIP(FLUSH_EIP),
    .IC_REQ(IC_REQ), .IC_ADDR(IC_ADDR), .IC_RDY(IC_RDY), .IC_LINE(IC_LINE),
    .DE_STALL(DE_STALL), .INSTR_TAKE(INSTR_TAKE), .INSTR_LEN(INSTR_LEN),
    .IR_OUT(IR_OUT), .IR_V(IR_V), .EIP_OUT(EIP_OUT), .BYTE_CNT(BYTE_CNT)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the byte stream is the address range [m_eip, m_faddr).
  logic [31:0] m_eip;
  logic [31:0] m_faddr;
  logic [7:0]  mem [logic [31:0]];

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  function automatic int m_cnt();
    int d;
    d = $signed(m_faddr - m_eip);
    return (d > 0) ? d : 0;
  endfunction

  function automatic logic m_req();
    return ((m_faddr - align(m_eip)) < 32'd32) && !FLUSH;
  endfunction

  function automatic logic m_irv();
    return (m_cnt() >= 15) && !FLUSH;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    int c;
    logic [127:0] exp_w;
    logic [127:0] mask;
    logic [31:0]  a;
    c = m_cnt();
    check({where, ".IC_REQ"},   128'(IC_REQ),   128'(m_req()));
    check({where, ".IC_ADDR"},  128'(IC_ADDR),  128'(m_faddr));
    check({where, ".IR_V"},     128'(IR_V),     128'(m_irv()));
    check({where, ".EIP_OUT"},  128'(EIP_OUT),  128'(m_eip));
    check({where, ".BYTE_CNT"}, 128'(BYTE_CNT), 128'(c));
    exp_w = '0;
    mask  = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < c) begin
        a = m_eip + 32'(k);
        mask[127-8*k -: 8]  = 8'hFF;
        exp_w[127-8*k -: 8] = mem.exists(a) ? mem[a] : 8'h00;
      end
    end
    if (c > 0) check({where, ".IR_OUT"}, IR_OUT & mask, exp_w);
  endtask

  task automatic model_edge();
    logic req;
    logic irv;
    req = m_req();
    irv = m_irv();
    if (FLUSH) begin
      m_eip   = FLUSH_EIP;
      m_faddr = align(FLUSH_EIP);
    end else begin
      if (req && IC_RDY) begin
        for (int i = 0; i < 16; i++) mem[m_faddr + 32'(i)] = IC_LINE[8*i +: 8];
        m_faddr = m_faddr + 32'd16;
      end
      if (irv && INSTR_TAKE && !DE_STALL) m_eip = m_eip + {28'd0, INSTR_LEN};
    end
  endtask

  task automatic drive(input logic fl, input logic [31:0] fe, input logic rdy,
                       input logic tk, input logic [3:0] ln, input logic st,
                       input logic counting);
    FLUSH      = fl;
    FLUSH_EIP  = fe;
    IC_RDY     = rdy;
    INSTR_TAKE = tk;
    INSTR_LEN  = ln;
    DE_STALL   = st;
    for (int i = 0; i < 16; i++)
      IC_LINE[8*i +: 8] = counting ? (m_faddr[7:0] + 8'(i)) : 8'($urandom);
  endtask

  task automatic cycle(input string where);
    #3;
    check_outputs(where);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
    #1;
  endtask

  initial begin
    CLR = 1'b0;
    m_eip = 32'h0;
    m_faddr = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
    #2;
    check_outputs("reset");
    check("reset.IC_REQ", 128'(IC_REQ), 128'(1'b1));
    @(posedge CLK);
    #1;
    CLR = 1'b1;

    // Two consecutive line returns fill the buffer.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    #1;
    check("fill0.IC_ADDR", 128'(IC_ADDR), 128'(32'h0));
    cycle("fill0");
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    #1;
    check("fill1.IC_ADDR", 128'(IC_ADDR), 128'(32'h10));
    cycle("fill1");
    idle();
    check("full.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd32));
    check("full.IC_REQ", 128'(IC_REQ), 128'(1'b0));
    check("full.IR_V", 128'(IR_V), 128'(1'b1));
    check("full.IR_OUT", IR_OUT, 128'h000102030405060708090A0B0C0D0E0F);

    // Consume 3 then 14: second crosses into slot 1 and frees slot 0.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    cycle("take3");
    idle();
    check("take3.EIP_OUT", 128'(EIP_OUT), 128'(32'h3));
    check("take3.byte0", 128'(IR_OUT[127:120]), 128'(8'h03));
    check("take3.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd29));
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
    cycle("take14");
    idle();
    check("take14.EIP_OUT", 128'(EIP_OUT), 128'(32'h11));
    check("take14.IC_REQ", 128'(IC_REQ), 128'(1'b1));
    check("take14.IC_ADDR", 128'(IC_ADDR), 128'(32'h20));

    // Redirect to an address two bytes before a line boundary.
    drive(1'b1, 32'h1234_567E, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
    #1;
    check("flush.IR_V", 128'(IR_V), 128'(1'b0));
    cycle("flush");
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    #1;
    check("rfill0.IC_ADDR", 128'(IC_ADDR), 128'(32'h1234_5670));
    cycle("rfill0");
    idle();
    check("rfill0.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd2));
    check("rfill0.IR_V", 128'(IR_V), 128'(1'b0));
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    cycle("rfill1");
    idle();
    check("rfill1.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd18));
    check("rfill1.IR_V", 128'(IR_V), 128'(1'b1));
    check("rfill1.EIP_OUT", 128'(EIP_OUT), 128'(32'h1234_567E));
    check("rfill1.byte0", 128'(IR_OUT[127:120]), 128'(8'h7E));

    // Walk head to 30, then take 15 across the 31->0 wrap.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
    cycle("walk15");
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    cycle("walkfill");
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
    cycle("walk1");
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
    cycle("wrap15");
    idle();
    check("wrap.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd3));
    check("wrap.EIP_OUT", 128'(EIP_OUT), 128'(32'h1234_569D));
    check("wrap.IC_REQ", 128'(IC_REQ), 128'(1'b1));
    check("wrap.IC_ADDR", 128'(IC_ADDR), 128'(32'h1234_56A0));
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    cycle("wfill");
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    cycle("wtake3");
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
    cycle("fill_and_take");
    idle();
    check("both.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd31));

    // Flush wins over a same-cycle fill and consume.
    drive(1'b1, 32'h0000_0105, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1);
    #1;
    check("flushall.IR_V", 128'(IR_V), 128'(1'b0));
    check("flushall.IC_REQ", 128'(IC_REQ), 128'(1'b0));
    cycle("flushall");
    idle();
    check("flushall.EIP_OUT", 128'(EIP_OUT), 128'(32'h0000_0105));
    check("flushall.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd0));
    check("flushall.IC_ADDR", 128'(IC_ADDR), 128'(32'h0000_0100));

    // Stall holds the consume side for three cycles.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    cycle("sfill0");
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    cycle("sfill1");
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
      cycle("stall");
    end
    idle();
    check("stall.EIP_OUT", 128'(EIP_OUT), 128'(32'h0000_0105));
    check("stall.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd27));
    check("stall.IR_V", 128'(IR_V), 128'(1'b1));

    // Reset between edges acts at once.
    #1;
    CLR = 1'b0;
    #1;
    m_eip = 32'h0;
    m_faddr = 32'h0;
    check("async.IR_V", 128'(IR_V), 128'(1'b0));
    check("async.BYTE_CNT", 128'(BYTE_CNT), 128'(6'd0));
    check("async.EIP_OUT", 128'(EIP_OUT), 128'(32'h0));
    check_outputs("async");
    @(posedge CLK);
    #1;
    CLR = 1'b1;

    // Random traffic against the stream model.
    for (int n = 0; n < 600; n++) begin
      logic fl;
      logic [31:0] fe;
      fl = ($urandom_range(0, 39) == 0);
      fe = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom);
      drive(fl, fe, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6),
            4'($urandom_range(1, int'(MAX_INSTR_LEN))), ($urandom_range(0, 4) == 0), 1'b0);
      cycle("rand");
    end
    idle();
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
